// File: rtl/led_matrix_pwm_driver.sv
// Per-column PWM brightness driver for an 8x8 LED matrix.
// Holds a 64-entry brightness memory, snapshots the active column into a
// shadow register, and drives one-hot columns plus PWM rows with dead-time
// blanking between columns.
module led_matrix_pwm_driver #(
    parameter int PWM_BITS    = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                COL_CE,
    input  logic [2:0]          COL_SEL,
    input  logic                TICK,
    input  logic                WR_EN,
    input  logic [5:0]          WR_ADDR,
    input  logic [PWM_BITS-1:0] WR_DATA,
    output logic [7:0]          ROW_OUT,
    output logic [7:0]          COL_OUT,
    output logic                FRAME_SYNC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_LOAD,
        S_DRIVE,
        S_HOLD
    } state_t;

    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
    // Only reached when DEAD_CYCLES > 0; with 0 the FSM skips BLANK entirely.
    localparam logic [3:0]          DEAD_LAST = 4'(DEAD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          col_q, col_d;
    logic [3:0]          dead_q, dead_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] mem_q    [64];
    logic [PWM_BITS-1:0] shadow_q [8];
    logic [7:0]          row_q, row_d;
    logic [7:0]          colo_q, colo_d;
    logic                fsync_q, fsync_d;

    // Brightness memory: writes land in any state; reads see the pre-write value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) mem_q[i] <= '0;
        end else if (WR_EN) begin
            mem_q[WR_ADDR] <= WR_DATA;
        end
    end

    // Shadow snapshot of the active column, taken only in LOAD so brightness
    // stays constant for a whole column slot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < 8; r++) shadow_q[r] <= '0;
        end else if (state_q == S_LOAD) begin
            for (int r = 0; r < 8; r++) shadow_q[r] <= mem_q[{col_q, 3'(r)}];
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            dead_q  <= '0;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
        end
    end

    // Next-state logic; a column strobe overrides everything and restarts blanking.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dead_d  = dead_q;
        pwm_d   = pwm_q;
        unique case (state_q)
            S_IDLE: ;
            S_BLANK: begin
                if (dead_q == DEAD_LAST) state_d = S_LOAD;
                else                     dead_d  = dead_q + 4'd1;
            end
            S_LOAD: begin
                pwm_d   = '0;
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (TICK) begin
                    if (pwm_q == PWM_MAX) begin
                        pwm_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        pwm_d = pwm_q + 1'b1;
                    end
                end
            end
            S_HOLD: ;
            default: state_d = S_IDLE;
        endcase
        if (COL_CE) begin
            col_d   = COL_SEL;
            dead_d  = '0;
            state_d = (DEAD_CYCLES == 0) ? S_LOAD : S_BLANK;
        end
    end

    // Output decode; a column strobe blanks outputs on the very next edge.
    always_comb begin
        row_d   = '0;
        colo_d  = '0;
        fsync_d = COL_CE && (COL_SEL == 3'd0);
        if (state_q == S_DRIVE && !COL_CE) begin
            colo_d = 8'd1 << col_q;
            for (int r = 0; r < 8; r++) row_d[r] = (pwm_q < shadow_q[r]);
        end
    end

    // Registered outputs, cleared immediately on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q   <= '0;
            colo_q  <= '0;
            fsync_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            colo_q  <= colo_d;
            fsync_q <= fsync_d;
        end
    end

    assign ROW_OUT    = row_q;
    assign COL_OUT    = colo_q;
    assign FRAME_SYNC = fsync_q;

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Scoreboard bench for led_matrix_pwm_driver: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_led_matrix_pwm_driver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       COL_CE = 1'b0;
    logic [2:0] COL_SEL = '0;
    logic       TICK = 1'b0;
    logic       WR_EN = 1'b0;
    logic [5:0] WR_ADDR = '0;
    logic [3:0] WR_DATA = '0;
    logic [7:0] ROW_OUT, COL_OUT;
    logic       FRAME_SYNC;
    logic [7:0] row_d0, col_d0, row_d5, col_d5;
    logic       fs_d0, fs_d5;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [7:0] row;
        logic [7:0] col;
        logic       fs;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    led_matrix_pwm_driver #(.PWM_BITS(4), .DEAD_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .COL_CE(COL_CE), .COL_SEL(COL_SEL), .TICK(TICK),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ROW_OUT(ROW_OUT), .COL_OUT(COL_OUT), .FRAME_SYNC(FRAME_SYNC));

    led_matrix_pwm_driver #(.PWM_BITS(4), .DEAD_CYCLES(0)) dut_d0 (
        .CLK(CLK), .RST(RST), .COL_CE(COL_CE), .COL_SEL(COL_SEL), .TICK(TICK),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ROW_OUT(row_d0), .COL_OUT(col_d0), .FRAME_SYNC(fs_d0));

    led_matrix_pwm_driver #(.PWM_BITS(4), .DEAD_CYCLES(5)) dut_d5 (
        .CLK(CLK), .RST(RST), .COL_CE(COL_CE), .COL_SEL(COL_SEL), .TICK(TICK),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .ROW_OUT(row_d5), .COL_OUT(col_d5), .FRAME_SYNC(fs_d5));

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation once its edge has happened.
    always @(negedge CLK) begin
        if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.nm, "_align"}, cyc, e.cyc);
            chk({e.nm, "_row"}, {24'd0, ROW_OUT}, {24'd0, e.row});
            chk({e.nm, "_col"}, {24'd0, COL_OUT}, {24'd0, e.col});
            chk({e.nm, "_fs"}, {31'd0, FRAME_SYNC}, {31'd0, e.fs});
        end
    end

    // One clock of stimulus; optionally records the outputs expected after this edge.
    task automatic step(input logic ce, input logic [2:0] sel, input logic tk,
                        input logic we, input logic [5:0] wa, input logic [3:0] wd,
                        input logic push, input logic [7:0] erow, input logic [7:0] ecol,
                        input logic efs, input string nm);
        exp_t e;
        COL_CE  = ce;
        COL_SEL = sel;
        TICK    = tk;
        WR_EN   = we;
        WR_ADDR = wa;
        WR_DATA = wd;
        if (push) begin
            e.cyc = cyc + 1;
            e.row = erow;
            e.col = ecol;
            e.fs  = efs;
            e.nm  = nm;
            sb_q.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic write_col(input logic [2:0] c, input logic [31:0] lv);
        for (int r = 0; r < 8; r++)
            step(1'b0, 3'd0, 1'b0, 1'b1, {c, 3'(r)}, lv[4*r +: 4], 1'b1, 8'h00, 8'h00, 1'b0, "wr");
    endtask

    // Full column slot at DEAD_CYCLES=2 with TICK=1; optional write in the LOAD cycle.
    task automatic drive_column(input logic [2:0] sel, input logic [31:0] lv,
                                input logic cwe, input logic [5:0] cwa, input logic [3:0] cwd,
                                input string nm);
        logic [7:0] erow;
        step(1'b1, sel, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, sel == 3'd0, {nm, "_ce"});
        step(1'b0, sel, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, {nm, "_blank"});
        step(1'b0, sel, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, {nm, "_blank"});
        step(1'b0, sel, 1'b1, cwe, cwa, cwd, 1'b1, 8'h00, 8'h00, 1'b0, {nm, "_load"});
        for (int j = 0; j < 16; j++) begin
            for (int r = 0; r < 8; r++) erow[r] = (j < int'(lv[4*r +: 4]));
            step(1'b0, sel, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, erow, 8'd1 << sel, 1'b0, {nm, "_drive"});
        end
        step(1'b0, sel, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, {nm, "_hold"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_row", {24'd0, ROW_OUT}, 32'd0);
        chk("rst_col", {24'd0, COL_OUT}, 32'd0);
        chk("rst_fs", {31'd0, FRAME_SYNC}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "idle");

        // Basic column drive: levels 0,1,2,4,8,12,15,15 on column 3
        write_col(3'd3, 32'hFFC8_4210);
        drive_column(3'd3, 32'hFFC8_4210, 1'b0, 6'd0, 4'd0, "basic");

        // Dead time: strobe at relative cycle 10, column 1 (all levels 0)
        for (int i = 0; i < 10; i++)
            step(1'b0, 3'd0, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "pre_dead");
        for (int i = 0; i <= 20; i++) begin
            step(i == 0, 3'd1, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00,
                 (i >= 4 && i < 20) ? 8'h02 : 8'h00, 1'b0, "dead_main");
            if (i == 1) chk("dead0_col_k1", {24'd0, col_d0}, 32'h00);
            if (i == 2) chk("dead0_col_k2", {24'd0, col_d0}, 32'h02);
            if (i == 6) chk("dead5_col_k6", {24'd0, col_d5}, 32'h00);
            if (i == 7) chk("dead5_col_k7", {24'd0, col_d5}, 32'h02);
        end

        // Abort: column 2 at full brightness, restrike with column 0 at pwm_cnt=7
        write_col(3'd2, 32'hFFFF_FFFF);
        write_col(3'd0, 32'hF7A5_3210);
        step(1'b1, 3'd2, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "abort_ce");
        repeat (3) step(1'b0, 3'd2, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "abort_blank");
        for (int j = 0; j < 7; j++)
            step(1'b0, 3'd2, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'hFF, 8'h04, 1'b0, "abort_drive");
        drive_column(3'd0, 32'hF7A5_3210, 1'b0, 6'd0, 4'd0, "col0");

        // Write collision: row 2 of column 5 is 3, rewritten to 9 during LOAD
        write_col(3'd5, 32'h0000_0300);
        drive_column(3'd5, 32'h0000_0300, 1'b1, {3'd5, 3'd2}, 4'd9, "coll_old");
        drive_column(3'd5, 32'h0000_0900, 1'b0, 6'd0, 4'd0, "coll_new");

        // TICK gating: level 15, tick every 3rd DRIVE cycle
        write_col(3'd7, 32'hFFFF_FFFF);
        step(1'b1, 3'd7, 1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "tick_ce");
        repeat (3) step(1'b0, 3'd7, 1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "tick_blank");
        for (int i = 1; i <= 48; i++)
            step(1'b0, 3'd7, (i % 3) == 0, 1'b0, 6'd0, 4'd0, 1'b1,
                 (i <= 45) ? 8'hFF : 8'h00, 8'h80, 1'b0, "tick_drive");
        step(1'b0, 3'd7, 1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "tick_hold");

        // Reset asserted mid-DRIVE with all rows on
        step(1'b1, 3'd7, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "mrst_ce");
        repeat (3) step(1'b0, 3'd7, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "mrst_blank");
        repeat (5) step(1'b0, 3'd7, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'hFF, 8'h80, 1'b0, "mrst_drive");
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("mrst_row", {24'd0, ROW_OUT}, 32'd0);
        chk("mrst_col", {24'd0, COL_OUT}, 32'd0);
        chk("mrst_fs", {31'd0, FRAME_SYNC}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (10) step(1'b0, 3'd7, 1'b1, 1'b0, 6'd0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, "post_rst");

        repeat (2) @(posedge CLK);
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
